// File: rtl/seg7_stopwatch_scan.sv
// MM:SS BCD stopwatch advanced by a synchronised 1 Hz strobe, shown on a
// four-digit common-anode 7-segment display scanned by a synchronised 220 Hz strobe.
module seg7_stopwatch_scan #(
    parameter int LEADING_BLANK = 0,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       Clk_8MHz,
    input  logic       Reset,
    input  logic       Clk_1Hz,
    input  logic       Clk_220Hz,
    input  logic       Run,
    input  logic       Clear,
    output logic [7:0] Sec_bcd,
    output logic [7:0] Min_bcd,
    output logic [3:0] Anode,
    output logic [6:0] Seg,
    output logic       Dp
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D0   = 3'd1,
        D1   = 3'd2,
        D2   = 3'd3,
        D3   = 3'd4
    } scan_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    // Returns {carry, next digit}; anything at or above the limit wraps to 0,
    // so a corrupted digit recovers to a legal value on the next tick.
    function automatic logic [4:0] digit_inc(input logic [3:0] digit, input logic [3:0] limit);
        logic [4:0] result;
        if (digit >= limit) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

    logic [SYNC_STAGES-1:0] sync_1hz_r;
    logic [SYNC_STAGES-1:0] sync_220_r;
    logic                   prev_1hz_r;
    logic                   prev_220_r;
    logic                   level_1hz_s;
    logic                   level_220_s;
    logic                   tick_1hz_s;
    logic                   tick_220_s;

    logic [3:0] sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
    logic [3:0] sec_ones_nxt_s, sec_tens_nxt_s, min_ones_nxt_s, min_tens_nxt_s;
    logic [3:0] sec_ones_inc_s, sec_tens_inc_s, min_ones_inc_s, min_tens_inc_s;
    logic       sec_ones_cy_s, sec_tens_cy_s, min_ones_cy_s, min_tens_cy_s;

    scan_state_t state_r, state_nxt_s;

    logic [3:0] anode_r, anode_nxt_s;
    logic [6:0] seg_r, seg_nxt_s;
    logic       dp_r, dp_nxt_s;

    assign level_1hz_s = sync_1hz_r[SYNC_STAGES-1];
    assign level_220_s = sync_220_r[SYNC_STAGES-1];
    assign tick_1hz_s  = level_1hz_s & ~prev_1hz_r;
    assign tick_220_s  = level_220_s & ~prev_220_r;

    // Synchroniser chains and previous-level registers for both strobes.
    always_ff @(posedge Clk_8MHz) begin
        if (Reset) begin
            sync_1hz_r <= '0;
            sync_220_r <= '0;
            prev_1hz_r <= 1'b0;
            prev_220_r <= 1'b0;
        end else begin
            sync_1hz_r <= {sync_1hz_r[SYNC_STAGES-2:0], Clk_1Hz};
            sync_220_r <= {sync_220_r[SYNC_STAGES-2:0], Clk_220Hz};
            prev_1hz_r <= level_1hz_s;
            prev_220_r <= level_220_s;
        end
    end

    // Next count: ripple carry through the four BCD digits on an enabled tick.
    always_comb begin
        {sec_ones_cy_s, sec_ones_inc_s} = digit_inc(sec_ones_r, 4'd9);
        {sec_tens_cy_s, sec_tens_inc_s} = digit_inc(sec_tens_r, 4'd5);
        {min_ones_cy_s, min_ones_inc_s} = digit_inc(min_ones_r, 4'd9);
        {min_tens_cy_s, min_tens_inc_s} = digit_inc(min_tens_r, 4'd5);
        sec_ones_nxt_s = sec_ones_r;
        sec_tens_nxt_s = sec_tens_r;
        min_ones_nxt_s = min_ones_r;
        min_tens_nxt_s = min_tens_r;
        if (tick_1hz_s && Run) begin
            sec_ones_nxt_s = sec_ones_inc_s;
            if (sec_ones_cy_s) begin
                sec_tens_nxt_s = sec_tens_inc_s;
                if (sec_tens_cy_s) begin
                    min_ones_nxt_s = min_ones_inc_s;
                    if (min_ones_cy_s) begin
                        min_tens_nxt_s = min_tens_inc_s;
                    end else begin
                        min_tens_nxt_s = min_tens_r;
                    end
                end else begin
                    min_ones_nxt_s = min_ones_r;
                end
            end else begin
                sec_tens_nxt_s = sec_tens_r;
            end
        end else begin
            sec_ones_nxt_s = sec_ones_r;
        end
    end

    // Count registers; Clear wins over a simultaneous tick.
    always_ff @(posedge Clk_8MHz) begin
        if (Reset || Clear) begin
            sec_ones_r <= 4'd0;
            sec_tens_r <= 4'd0;
            min_ones_r <= 4'd0;
            min_tens_r <= 4'd0;
        end else begin
            sec_ones_r <= sec_ones_nxt_s;
            sec_tens_r <= sec_tens_nxt_s;
            min_ones_r <= min_ones_nxt_s;
            min_tens_r <= min_tens_nxt_s;
        end
    end

    assign Sec_bcd = {sec_tens_r, sec_ones_r};
    assign Min_bcd = {min_tens_r, min_ones_r};

    // Scan state register.
    always_ff @(posedge Clk_8MHz) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scan next state: one digit step per 220 Hz edge; IDLE only left, never re-entered.
    always_comb begin
        state_nxt_s = state_r;
        if (tick_220_s) begin
            case (state_r)
                IDLE:    state_nxt_s = D0;
                D0:      state_nxt_s = D1;
                D1:      state_nxt_s = D2;
                D2:      state_nxt_s = D3;
                D3:      state_nxt_s = D0;
                default: state_nxt_s = D0;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Display drive for the current digit, registered one stage below.
    always_comb begin
        anode_nxt_s = 4'b1111;
        seg_nxt_s   = 7'b1111111;
        dp_nxt_s    = 1'b1;
        case (state_r)
            D0: begin
                anode_nxt_s = 4'b1110;
                seg_nxt_s   = seg_decode(sec_ones_r);
            end
            D1: begin
                anode_nxt_s = 4'b1101;
                seg_nxt_s   = seg_decode(sec_tens_r);
            end
            D2: begin
                anode_nxt_s = 4'b1011;
                seg_nxt_s   = seg_decode(min_ones_r);
                dp_nxt_s    = ~level_1hz_s;
            end
            D3: begin
                anode_nxt_s = 4'b0111;
                if ((LEADING_BLANK != 0) && (min_tens_r == 4'd0)) begin
                    seg_nxt_s = 7'b1111111;
                end else begin
                    seg_nxt_s = seg_decode(min_tens_r);
                end
            end
            default: begin
                anode_nxt_s = 4'b1111;
                seg_nxt_s   = 7'b1111111;
                dp_nxt_s    = 1'b1;
            end
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge Clk_8MHz) begin
        if (Reset) begin
            anode_r <= 4'b1111;
            seg_r   <= 7'b1111111;
            dp_r    <= 1'b1;
        end else begin
            anode_r <= anode_nxt_s;
            seg_r   <= seg_nxt_s;
            dp_r    <= dp_nxt_s;
        end
    end

    assign Anode = anode_r;
    assign Seg   = seg_r;
    assign Dp    = dp_r;

endmodule

// File: tb/tb_seg7_stopwatch_scan.sv
// Directed bench for seg7_stopwatch_scan: two instances (no blanking / leading
// blanking) share stimulus; expected count comes from an integer-seconds model.
module tb_seg7_stopwatch_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1hz = 1'b0;
    logic       s220 = 1'b0;
    logic       run = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] sec0, min0, sec1, min1;
    logic [3:0] anode0, anode1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;

    int total = 0;
    int bad   = 0;
    int model = 0;

    seg7_stopwatch_scan #(.LEADING_BLANK(0), .SYNC_STAGES(2)) u_dut (
        .Clk_8MHz(clk), .Reset(rst), .Clk_1Hz(s1hz), .Clk_220Hz(s220),
        .Run(run), .Clear(clr), .Sec_bcd(sec0), .Min_bcd(min0),
        .Anode(anode0), .Seg(seg0), .Dp(dp0)
    );

    seg7_stopwatch_scan #(.LEADING_BLANK(1), .SYNC_STAGES(2)) u_dut_blank (
        .Clk_8MHz(clk), .Reset(rst), .Clk_1Hz(s1hz), .Clk_220Hz(s220),
        .Run(run), .Clear(clr), .Sec_bcd(sec1), .Min_bcd(min1),
        .Anode(anode1), .Seg(seg1), .Dp(dp1)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_pulse();
        s220 = 1'b1;
        clocks(8);
        s220 = 1'b0;
        clocks(8);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s1hz = 1'b1;
            clocks(8);
            s1hz = 1'b0;
            clocks(8);
            if (run) model = (model + 1) % 3600;
            check("cnt_sec", sec0, bcd(model % 60));
            check("cnt_min", min0, bcd(model / 60));
        end
    endtask

    initial begin
        // reset, two cycles with strobes low
        clocks(2);
        check("rst_sec", sec0, 8'h00);
        check("rst_min", min0, 8'h00);
        check("rst_anode", {4'd0, anode0}, 8'h0F);
        check("rst_seg", {1'b0, seg0}, 8'h7F);
        check("rst_dp", {7'd0, dp0}, 8'h01);
        rst = 1'b0;
        clocks(2);
        check("idle_anode", {4'd0, anode0}, 8'h0F);

        // scan entry and order
        scan_pulse();
        check("d0_anode", {4'd0, anode0}, 8'h0E);
        check("d0_seg", {1'b0, seg0}, {1'b0, 7'b1000000});
        scan_pulse();
        check("d1_anode", {4'd0, anode0}, 8'h0D);
        scan_pulse();
        check("d2_anode", {4'd0, anode0}, 8'h0B);
        check("d2_dp_low1hz", {7'd0, dp0}, 8'h01);
        s1hz = 1'b1;
        clocks(4);
        check("d2_dp_high1hz", {7'd0, dp0}, 8'h00);
        check("d2_dp_high1hz_b", {7'd0, dp1}, 8'h00);
        check("run0_no_count", sec0, 8'h00);
        s1hz = 1'b0;
        clocks(4);
        check("d2_dp_back", {7'd0, dp0}, 8'h01);
        scan_pulse();
        check("d3_anode", {4'd0, anode0}, 8'h07);
        check("d3_seg_zero", {1'b0, seg0}, {1'b0, 7'b1000000});
        check("d3_seg_blank", {1'b0, seg1}, 8'h7F);
        s1hz = 1'b1;
        clocks(4);
        check("d3_dp_off", {7'd0, dp0}, 8'h01);
        s1hz = 1'b0;
        clocks(8);
        scan_pulse();
        check("wrap_d0_anode", {4'd0, anode0}, 8'h0E);
        scan_pulse();
        scan_pulse();
        scan_pulse();
        check("park_d3_anode", {4'd0, anode0}, 8'h07);

        // full wrap with carries
        run = 1'b1;
        run_ticks(9);
        check("c_0009", sec0, 8'h09);
        run_ticks(1);
        check("c_0010_sec", sec0, 8'h10);
        check("c_0010_min", min0, 8'h00);
        run_ticks(589);
        check("c_0959_sec", sec0, 8'h59);
        check("c_0959_min", min0, 8'h09);
        run_ticks(1);
        check("c_1000_sec", sec0, 8'h00);
        check("c_1000_min", min0, 8'h10);
        check("c_1000_d3seg", {1'b0, seg0}, {1'b0, 7'b1111001});
        check("c_1000_d3seg_b", {1'b0, seg1}, {1'b0, 7'b1111001});
        run_ticks(2999);
        check("w_5959_sec", sec0, 8'h59);
        check("w_5959_min", min0, 8'h59);
        check("w_5959_sec_b", sec1, 8'h59);
        check("w_5959_d3seg", {1'b0, seg0}, {1'b0, 7'b0010010});
        run_ticks(1);
        check("w_0000_sec", sec0, 8'h00);
        check("w_0000_min", min0, 8'h00);
        check("w_0000_min_b", min1, 8'h00);

        // Run=0 discards ticks
        run_ticks(42);
        check("r_0042", sec0, 8'h42);
        run = 1'b0;
        run_ticks(5);
        check("r_hold", sec0, 8'h42);
        run = 1'b1;
        clocks(20);
        check("r_no_replay", sec0, 8'h42);

        // Clear coincident with a detected edge
        s1hz = 1'b1;
        clocks(2);
        clr = 1'b1;
        clocks(1);
        clr = 1'b0;
        model = 0;
        check("clr_tick_sec", sec0, 8'h00);
        check("clr_tick_min", min0, 8'h00);
        clocks(6);
        s1hz = 1'b0;
        clocks(8);
        check("clr_tick_after", sec0, 8'h00);

        // Clear with Run=0
        run_ticks(1);
        check("clr_r0_pre", sec0, 8'h01);
        run = 1'b0;
        clr = 1'b1;
        clocks(1);
        clr = 1'b0;
        model = 0;
        check("clr_r0", sec0, 8'h00);
        run = 1'b1;

        // leading blank at 05:30
        run_ticks(330);
        check("lb_sec", sec0, 8'h30);
        check("lb_min", min0, 8'h05);
        check("lb_seg_blank", {1'b0, seg1}, 8'h7F);
        check("lb_anode_blank", {4'd0, anode1}, 8'h07);
        check("lb_seg_noblank", {1'b0, seg0}, {1'b0, 7'b1000000});

        // reset at 12:34 while in D2
        run_ticks(424);
        check("m_1234_sec", sec0, 8'h34);
        check("m_1234_min", min0, 8'h12);
        scan_pulse();
        scan_pulse();
        scan_pulse();
        check("m_d2_anode", {4'd0, anode0}, 8'h0B);
        check("m_d2_seg", {1'b0, seg0}, {1'b0, 7'b0100100});
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
        check("mr_sec", sec0, 8'h00);
        check("mr_min", min0, 8'h00);
        check("mr_anode", {4'd0, anode0}, 8'h0F);
        check("mr_seg", {1'b0, seg0}, 8'h7F);
        model = 0;
        clocks(4);
        check("mr_idle_anode", {4'd0, anode0}, 8'h0F);
        scan_pulse();
        check("mr_d0_anode", {4'd0, anode0}, 8'h0E);
        check("mr_d0_seg", {1'b0, seg0}, {1'b0, 7'b1000000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
